// File: rtl/gtxe2_chnl_rx_oob.sv
// SATA OOB receive detector: times bursts and gaps on the line-idle indication
// and reports complete COMINIT/COMRESET or COMWAKE sequences as one-cycle pulses.
module gtxe2_chnl_rx_oob #(
    parameter int         BURST_MIN          = 12,
    parameter int         BURST_MAX          = 20,
    parameter int         WAKE_GAP_MIN       = 12,
    parameter int         WAKE_GAP_MAX       = 20,
    parameter int         INIT_GAP_MIN       = 40,
    parameter int         INIT_GAP_MAX       = 56,
    parameter logic [3:0] SATA_BURST_SEQ_LEN = 4'd4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_idle,
    output logic RXCOMINITDET,
    output logic RXCOMWAKEDET,
    output logic oob_active
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;
    typedef enum logic [1:0] {SEQ_NONE, SEQ_INIT, SEQ_WAKE} seq_t;

    localparam logic [7:0] B_MIN  = 8'(BURST_MIN);
    localparam logic [7:0] B_MAX  = 8'(BURST_MAX);
    localparam logic [7:0] WG_MIN = 8'(WAKE_GAP_MIN);
    localparam logic [7:0] WG_MAX = 8'(WAKE_GAP_MAX);
    localparam logic [7:0] IG_MIN = 8'(INIT_GAP_MIN);
    localparam logic [7:0] IG_MAX = 8'(INIT_GAP_MAX);

    state_t     state_q, state_d;
    seq_t       seq_type_q, seq_type_d;
    seq_t       gap_class;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [3:0] nburst_q, nburst_d;
    logic [3:0] nburst_inc;
    logic       init_det_q, init_det_d;
    logic       wake_det_q, wake_det_d;
    logic       oob_active_q, oob_active_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d      = state_q;
        seq_type_d   = seq_type_q;
        burst_cnt_d  = burst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        nburst_d     = nburst_q;
        init_det_d   = 1'b0;
        wake_det_d   = 1'b0;
        nburst_inc   = nburst_q + 4'd1;

        // A gap outside both windows classifies as NONE, i.e. bad.
        if (gap_cnt_q >= WG_MIN && gap_cnt_q <= WG_MAX)
            gap_class = SEQ_WAKE;
        else if (gap_cnt_q >= IG_MIN && gap_cnt_q <= IG_MAX)
            gap_class = SEQ_INIT;
        else
            gap_class = SEQ_NONE;

        case (state_q)
            S_IDLE: begin
                if (!rx_idle) begin
                    state_d     = S_BURST;
                    burst_cnt_d = 8'd1;
                    nburst_d    = 4'd0;
                    seq_type_d  = SEQ_NONE;
                end
            end
            S_BURST: begin
                if (!rx_idle) begin
                    burst_cnt_d = sat_inc(burst_cnt_q);
                end else if (burst_cnt_q >= B_MIN && burst_cnt_q <= B_MAX) begin
                    nburst_d = nburst_inc;
                    if (nburst_inc == SATA_BURST_SEQ_LEN) begin
                        init_det_d = (seq_type_q == SEQ_INIT);
                        wake_det_d = (seq_type_q == SEQ_WAKE);
                        state_d    = S_IDLE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = 8'd1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (rx_idle) begin
                    gap_cnt_d = sat_inc(gap_cnt_q);
                    if (gap_cnt_d > IG_MAX)
                        state_d = S_IDLE;
                end else begin
                    state_d     = S_BURST;
                    burst_cnt_d = 8'd1;
                    // A mismatching gap makes the current burst the first of a new candidate.
                    if (gap_class != SEQ_NONE &&
                        (seq_type_q == SEQ_NONE || seq_type_q == gap_class)) begin
                        seq_type_d = gap_class;
                    end else begin
                        nburst_d   = 4'd0;
                        seq_type_d = SEQ_NONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        oob_active_d = (state_d != S_IDLE) && (nburst_d != 4'd0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            seq_type_q   <= SEQ_NONE;
            burst_cnt_q  <= 8'd0;
            gap_cnt_q    <= 8'd0;
            nburst_q     <= 4'd0;
            init_det_q   <= 1'b0;
            wake_det_q   <= 1'b0;
            oob_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_type_q   <= seq_type_d;
            burst_cnt_q  <= burst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            nburst_q     <= nburst_d;
            init_det_q   <= init_det_d;
            wake_det_q   <= wake_det_d;
            oob_active_q <= oob_active_d;
        end
    end

    assign RXCOMINITDET = init_det_q;
    assign RXCOMWAKEDET = wake_det_q;
    assign oob_active   = oob_active_q;

endmodule
